// File: rtl/spi_fifo_pkg.sv
// Shared sizing for the SPI TX/RX FIFO instances.
package spi_fifo_pkg;
    localparam int SPI_FIFO_DW = 8;
    localparam int SPI_FIFO_AW = 3;

    function automatic int fifo_depth(input int aw);
        return 1 << aw;
    endfunction
endpackage

// File: rtl/spi_fifo_sync_param_if.sv
// FIFO control/data bundle: master drives requests, slave (the FIFO) returns data and status.
interface spi_fifo_sync_param_if
    import spi_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = SPI_FIFO_DW,
    parameter int ADDR_WIDTH = SPI_FIFO_AW
) ();
    logic                  flush;
    logic                  err_clr;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [ADDR_WIDTH:0]   level;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output flush, err_clr, wr_en, wr_data, rd_en,
        input  rd_data, full, empty, almost_full, almost_empty, level, overflow, underflow
    );
    modport slave (
        input  flush, err_clr, wr_en, wr_data, rd_en,
        output rd_data, full, empty, almost_full, almost_empty, level, overflow, underflow
    );
endinterface

// File: rtl/spi_fifo_ram.sv
// DEPTH x DATA_WIDTH storage: synchronous write, asynchronous read, no reset.
module spi_fifo_ram
    import spi_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = SPI_FIFO_DW,
    parameter int ADDR_WIDTH = SPI_FIFO_AW
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);
    localparam int DEPTH = fifo_depth(ADDR_WIDTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/spi_fifo_sync_param.sv
// Parametrised show-ahead FIFO with level, programmable thresholds, flush and sticky errors.
module spi_fifo_sync_param
    import spi_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = SPI_FIFO_DW,
    parameter int ADDR_WIDTH = SPI_FIFO_AW,
    parameter int AF_THRESH  = fifo_depth(ADDR_WIDTH) - 2,
    parameter int AE_THRESH  = 2
) (
    input logic                  clk,
    input logic                  rstn,
    spi_fifo_sync_param_if.slave bus
);
    localparam logic [ADDR_WIDTH:0] AF_L = AF_THRESH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AE_L = AE_THRESH[ADDR_WIDTH:0];

    logic [ADDR_WIDTH:0]   wptr_q, wptr_d, rptr_q, rptr_d, lvl;
    logic                  ovf_q, ovf_d, unf_q, unf_d;
    logic                  empty, full, rd_acc, wr_acc, ovf_evt, unf_evt;
    logic [DATA_WIDTH-1:0] ram_rdata;

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    assign lvl   = wptr_q - rptr_q;
    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[ADDR_WIDTH-1:0] == rptr_q[ADDR_WIDTH-1:0]) &&
                   (wptr_q[ADDR_WIDTH] != rptr_q[ADDR_WIDTH]);

    // Flush swallows any coincident request, including its error event.
    assign rd_acc  = bus.rd_en & ~empty & ~bus.flush;
    assign wr_acc  = bus.wr_en & ~bus.flush & (~full | rd_acc);
    assign ovf_evt = bus.wr_en & ~bus.flush & ~wr_acc;
    assign unf_evt = bus.rd_en & ~bus.flush & empty;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (bus.flush) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (wr_acc) wptr_d = wptr_q + 1'b1;
            if (rd_acc) rptr_d = rptr_q + 1'b1;
        end
        ovf_d = ovf_evt | (ovf_q & ~bus.err_clr);
        unf_d = unf_evt | (unf_q & ~bus.err_clr);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr_q <= '0;
            rptr_q <= '0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            ovf_q  <= ovf_d;
            unf_q  <= unf_d;
        end
    end

    spi_fifo_ram #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clk    (clk),
        .we_i   (wr_acc),
        .waddr_i(wptr_q[ADDR_WIDTH-1:0]),
        .wdata_i(bus.wr_data),
        .raddr_i(rptr_q[ADDR_WIDTH-1:0]),
        .rdata_o(ram_rdata)
    );

    assign bus.rd_data      = empty ? '0 : ram_rdata;
    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.almost_full  = (lvl >= AF_L);
    assign bus.almost_empty = (lvl <= AE_L);
    assign bus.level        = lvl;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = unf_q;
endmodule

// File: tb/tb_spi_fifo_sync_param.sv
// Scoreboard bench for spi_fifo_sync_param at DATA_WIDTH=8, DEPTH=8, AF=6, AE=2.
module tb_spi_fifo_sync_param;
    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    spi_fifo_sync_param_if #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) bus ();

    spi_fifo_sync_param #(
        .DATA_WIDTH(8),
        .ADDR_WIDTH(3),
        .AF_THRESH (6),
        .AE_THRESH (2)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus)
    );

    int         checks = 0;
    int         errors = 0;
    logic [7:0] sb[$];
    logic [7:0] exp_d;
    int         mlvl = 0;
    bit         movf = 1'b0;
    bit         munf = 1'b0;

    // {full, empty, almost_full, almost_empty, overflow, underflow, level}
    logic [9:0] st;
    assign st = {bus.full, bus.empty, bus.almost_full, bus.almost_empty,
                 bus.overflow, bus.underflow, bus.level};

    function automatic logic [9:0] exp_st(input int l, input bit o, input bit u);
        logic [3:0] lv;
        lv = 4'(l);
        return {l == 8, l == 0, l >= 6, l <= 2, o, u, lv};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.flush = 0; bus.err_clr = 0; bus.wr_en = 0; bus.rd_en = 0; bus.wr_data = '0;
    endtask

    task automatic fill(input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            bus.wr_en = 1; bus.wr_data = base + 8'(i);
            sb.push_back(base + 8'(i));
            step();
            mlvl++;
        end
        idle();
    endtask

    task automatic test_reset();
        idle();
        rstn = 0;
        #12 rstn = 1;
        step();
        checks++;
        if (st !== exp_st(0, 0, 0)) begin
            errors++; $display("FAIL reset_status got %b exp %b", st, exp_st(0, 0, 0));
        end
        checks++;
        if (bus.rd_data !== 8'h00) begin
            errors++; $display("FAIL reset_rd_data got %h exp 00", bus.rd_data);
        end
    endtask

    task automatic test_fill_overflow();
        for (int i = 0; i < 8; i++) begin
            bus.wr_en = 1; bus.wr_data = 8'h10 + 8'(i);
            sb.push_back(8'h10 + 8'(i));
            step();
            mlvl++;
            checks++;
            if (st !== exp_st(mlvl, movf, munf)) begin
                errors++; $display("FAIL fill_status lvl=%0d got %b exp %b", mlvl, st, exp_st(mlvl, movf, munf));
            end
        end
        bus.wr_data = 8'hFF;
        step();
        movf = 1;
        idle();
        checks++;
        if (st !== exp_st(mlvl, movf, munf)) begin
            errors++; $display("FAIL overflow_status got %b exp %b", st, exp_st(mlvl, movf, munf));
        end
        checks++;
        if (bus.rd_data !== sb[0]) begin
            errors++; $display("FAIL overflow_head got %h exp %h", bus.rd_data, sb[0]);
        end
    endtask

    task automatic test_drain_underflow();
        for (int i = 0; i < 8; i++) begin
            bus.rd_en = 1;
            exp_d = sb.pop_front();
            checks++;
            if (bus.rd_data !== exp_d) begin
                errors++; $display("FAIL drain_data idx=%0d got %h exp %h", i, bus.rd_data, exp_d);
            end
            step();
            mlvl--;
            checks++;
            if (st !== exp_st(mlvl, movf, munf)) begin
                errors++; $display("FAIL drain_status lvl=%0d got %b exp %b", mlvl, st, exp_st(mlvl, movf, munf));
            end
        end
        step();
        munf = 1;
        idle();
        checks++;
        if (st !== exp_st(mlvl, movf, munf) || bus.rd_data !== 8'h00) begin
            errors++; $display("FAIL underflow got st=%b data=%h exp st=%b data=00", st, bus.rd_data, exp_st(mlvl, movf, munf));
        end
        bus.err_clr = 1;
        step();
        movf = 0; munf = 0;
        idle();
        checks++;
        if (st !== exp_st(mlvl, movf, munf)) begin
            errors++; $display("FAIL err_clear got %b exp %b", st, exp_st(mlvl, movf, munf));
        end
    endtask

    task automatic test_back_to_back();
        fill(8'h10, 8);
        bus.wr_en = 1; bus.rd_en = 1; bus.wr_data = 8'hAA;
        exp_d = sb.pop_front();
        sb.push_back(8'hAA);
        checks++;
        if (bus.rd_data !== exp_d) begin
            errors++; $display("FAIL b2b_head got %h exp %h", bus.rd_data, exp_d);
        end
        step();
        idle();
        checks++;
        if (st !== exp_st(mlvl, movf, munf) || bus.rd_data !== sb[0]) begin
            errors++; $display("FAIL b2b_after got st=%b data=%h exp st=%b data=%h", st, bus.rd_data, exp_st(mlvl, movf, munf), sb[0]);
        end
        for (int i = 0; i < 8; i++) begin
            bus.rd_en = 1;
            exp_d = sb.pop_front();
            checks++;
            if (bus.rd_data !== exp_d) begin
                errors++; $display("FAIL wrap_data idx=%0d got %h exp %h", i, bus.rd_data, exp_d);
            end
            step();
            mlvl--;
        end
        idle();
        checks++;
        if (st !== exp_st(mlvl, movf, munf) || exp_d !== 8'hAA) begin
            errors++; $display("FAIL wrap_end got st=%b last=%h exp st=%b last=aa", st, exp_d, exp_st(mlvl, movf, munf));
        end
    endtask

    task automatic test_flush();
        fill(8'h30, 5);
        checks++;
        if (st !== exp_st(mlvl, movf, munf)) begin
            errors++; $display("FAIL preflush got %b exp %b", st, exp_st(mlvl, movf, munf));
        end
        bus.flush = 1; bus.wr_en = 1; bus.wr_data = 8'h55;
        step();
        sb.delete();
        mlvl = 0;
        idle();
        checks++;
        if (st !== exp_st(mlvl, movf, munf)) begin
            errors++; $display("FAIL flush_status got %b exp %b", st, exp_st(mlvl, movf, munf));
        end
        fill(8'h66, 1);
        exp_d = sb.pop_front();
        checks++;
        if (bus.rd_data !== exp_d) begin
            errors++; $display("FAIL flush_rewrite got %h exp %h", bus.rd_data, exp_d);
        end
        bus.rd_en = 1;
        step();
        mlvl = 0;
        idle();
        checks++;
        if (st !== exp_st(mlvl, movf, munf)) begin
            errors++; $display("FAIL flush_drain got %b exp %b", st, exp_st(mlvl, movf, munf));
        end
    endtask

    task automatic test_err_clr_and_async_reset();
        fill(8'h40, 8);
        bus.wr_en = 1; bus.wr_data = 8'hEE;
        step();
        movf = 1;
        bus.err_clr = 1;
        step();
        idle();
        checks++;
        if (st !== exp_st(mlvl, movf, munf)) begin
            errors++; $display("FAIL set_beats_clear got %b exp %b", st, exp_st(mlvl, movf, munf));
        end
        bus.err_clr = 1;
        step();
        movf = 0;
        idle();
        checks++;
        if (st !== exp_st(mlvl, movf, munf)) begin
            errors++; $display("FAIL clear_alone got %b exp %b", st, exp_st(mlvl, movf, munf));
        end
        bus.flush = 1;
        step();
        idle();
        sb.delete();
        mlvl = 0;
        fill(8'h50, 4);
        checks++;
        if (st !== exp_st(mlvl, movf, munf)) begin
            errors++; $display("FAIL prereset_level got %b exp %b", st, exp_st(mlvl, movf, munf));
        end
        #2 rstn = 0;
        #1;
        sb.delete();
        mlvl = 0;
        checks++;
        if (st !== exp_st(0, 0, 0) || bus.rd_data !== 8'h00) begin
            errors++; $display("FAIL async_reset got st=%b data=%h exp st=%b data=00", st, bus.rd_data, exp_st(0, 0, 0));
        end
        rstn = 1;
        step();
    endtask

    initial begin
        test_reset();
        test_fill_overflow();
        test_drain_underflow();
        test_back_to_back();
        test_flush();
        test_err_clr_and_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/spi_fifo_sync_param.md
Name: spi_fifo_sync_param

Overview:
Parametrised single-clock FIFO for the SPI datapath (TX and RX byte/word buffering). It generalises the 8-bit fixed FIFO to arbitrary width and power-of-two depth. It adds a fill-level output, programmable almost-full/almost-empty flags, synchronous flush, and sticky overflow/underflow error flags. Reads are show-ahead: rd_data always presents the head entry without a read-request latency.

Parameters:
DATA_WIDTH, 8, word width in bits (>=1)
ADDR_WIDTH, 3, log2 of depth; DEPTH = 2**ADDR_WIDTH (>=1)
AF_THRESH, DEPTH-2, almost_full asserted when level >= AF_THRESH (1..DEPTH)
AE_THRESH, 2, almost_empty asserted when level <= AE_THRESH (0..DEPTH-1)

Ports:
clk  in  1  clock, rising edge
rstn  in  1  reset, asynchronous, active-low
flush  in  1  synchronous clear of pointers and level; contents not erased
err_clr  in  1  synchronous clear of overflow/underflow
wr_en  in  1  write request
wr_data  in  DATA_WIDTH  write data
rd_en  in  1  read (pop) request
rd_data  out  DATA_WIDTH  head entry (show-ahead); 0 when empty
full  out  1  level == DEPTH
empty  out  1  level == 0
almost_full  out  1  level >= AF_THRESH
almost_empty  out  1  level <= AE_THRESH
level  out  ADDR_WIDTH+1  current entry count, 0..DEPTH
overflow  out  1  sticky: write attempted while rejected
underflow  out  1  sticky: read attempted while empty

Behaviour:
- Clock domain and reset: clk only; rstn is asynchronous, active-low.
- Reset values: wptr=rptr=0, level=0, empty=1, full=0, almost_empty=1, almost_full=0 (AF_THRESH>=1), overflow=0, underflow=0, rd_data=0. Storage array is not reset.
- Pointers are ADDR_WIDTH+1 bits; the MSB is a wrap bit. level = wptr - rptr, modulo 2**(ADDR_WIDTH+1). All flags decode combinationally from the registered pointers and update the cycle after the accepting edge.
- Read accept: rd_acc = rd_en & ~empty. On rd_acc, rptr increments. rd_data = mem[rptr[ADDR_WIDTH-1:0]] when ~empty, else 0. Data is valid in the same cycle rd_en is sampled (zero-latency pop).
- Write accept: wr_acc = wr_en & (~full | rd_acc). A write while full is accepted only if a read is accepted in the same cycle; level then stays DEPTH. On wr_acc, mem[wptr low bits] <= wr_data and wptr increments.
- Simultaneous wr_acc and rd_acc: level unchanged.
- Write while empty: the new word appears on rd_data the cycle after the write edge. There is no same-cycle bypass.
- Errors: overflow sets on wr_en & ~wr_acc; underflow sets on rd_en & empty. Both are sticky. err_clr clears them; if err_clr coincides with a new error event, set wins.
- Wrap-around: pointer low bits wrap naturally. full = (low bits equal & MSBs differ); empty = pointers equal.
- flush (priority over wr/rd in the same cycle): wptr=rptr=0 next edge; any coincident write/read is discarded and raises no error. Error flags are unaffected by flush.
- Reset mid-operation: immediate return to reset values regardless of clk.

Decomposition:
- Package spi_fifo_pkg holds the default DATA_WIDTH/ADDR_WIDTH constants and a DEPTH helper function shared by the SPI TX/RX instances.
- One sub-module, spi_fifo_ram: DEPTH x DATA_WIDTH array with one synchronous write port and one asynchronous read port, no reset.
- Pointer, flag and error logic stays in the top module.

Test Plan:
(Defaults: DATA_WIDTH=8, DEPTH=8, AF=6, AE=2.)
- Reset then idle: empty=1, almost_empty=1, full=0, level=0, rd_data=0x00, errors=0.
- Write 0x10..0x17 (8 writes), then 1 more write 0xFF: level steps 1..8; almost_empty drops at level 3; almost_full rises at level 6; full=1 at 8. The extra write is rejected, overflow=1, and rd_data stays 0x10.
- Read 8 words then 1 more: data order is 0x10..0x17 with rd_data valid same cycle; empty=1 after the 8th read; the 9th read sets underflow=1 and rd_data=0x00.
- Full FIFO, wr_en=rd_en=1 with 0xAA for 1 cycle: level stays 8, rd_data advances 0x10->0x11, no overflow. After 8 further reads, last word out is 0xAA (wrap-around verified).
- Level=5, assert flush with wr_en=1 (0x55): next cycle level=0, empty=1, no overflow; a subsequent write of 0x66 reads back as 0x66.
- overflow=1, assert err_clr and an overflow-causing write in the same cycle: overflow remains 1. err_clr alone next cycle: overflow=0. Async rstn pulse mid-fill (level 4): outputs return to reset values without a clk edge.
